// File: rtl/bus_pkg.sv
// Shared definitions for the bus requester: FSM states, active-low
// request/grant encodings and the per-beat address stride.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_e;

  // Arbiter request/grant lines are active-low.
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  // Each beat moves one 32-bit word.
  localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Per-beat wait counter. Counts cycles while enabled; expire is high during
// the MAX-th consecutive waiting cycle so the owner can abort on that edge.
module bus_timeout_cnt #(
  parameter int unsigned MAX = 255
) (
  input  logic bus_clk,
  input  logic bus_rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (MAX < 2) ? 1 : $clog2(MAX);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] count;

  // Count waiting cycles, saturating at the last value.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/bus_requester.sv
// Bus requester: accepts a local burst command, requests the bus from the
// arbiter, issues one beat at a time and returns read data.
//
// Handshakes: cmd and wd transfer on a rising edge where valid && ready are
// both high; bus beats complete on an edge where bus_valid && bus_ack are both
// high (bus_ack is ignored while bus_valid is low); rd_valid has no
// backpressure and is a single-cycle pulse.
module bus_requester
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wd_valid,
  input  logic [31:0] wd_data,
  output logic        wd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        done,
  output logic        err,
  output logic        reqn,
  input  logic        grntn,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  state_e     state;
  logic       wr_q;
  logic [3:0] len_q;
  logic [3:0] beat_q;
  logic       wait_en;
  logic       wait_clr;
  logic       expire;
  logic       last_beat;

  assign last_beat = (beat_q == len_q);
  assign dbg_state = state;

  // Write data is taken only when no beat is outstanding and the grant holds,
  // so an abort never swallows a data word.
  assign wd_ready = (state == XFER) && wr_q && !bus_valid && (grntn == ENABLE);

  // Only cycles stalled on bus_ack count; waiting for wd_valid does not.
  assign wait_en  = bus_valid && !bus_ack;
  assign wait_clr = !bus_valid || bus_ack || (state != XFER);

  bus_timeout_cnt #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .clear   (wait_clr),
    .enable  (wait_en),
    .expire  (expire)
  );

  // Main control FSM with registered bus and local outputs.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      cmd_ready <= 1'b0;
      reqn      <= DISABLE;
      bus_valid <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wr_q      <= cmd_write;
            bus_addr  <= cmd_addr;
            len_q     <= cmd_len;
            beat_q    <= '0;
            reqn      <= ENABLE;
            cmd_ready <= 1'b0;
            state     <= REQ;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        REQ: begin
          if (grntn == ENABLE) begin
            state <= XFER;
          end
        end
        XFER: begin
          if ((grntn == DISABLE) || expire) begin
            bus_valid <= 1'b0;
            reqn      <= DISABLE;
            err       <= 1'b1;
            state     <= REL;
          end else if (bus_valid) begin
            if (bus_ack) begin
              bus_valid <= 1'b0;
              bus_addr  <= bus_addr + ADDR_STRIDE;
              if (!wr_q) begin
                rd_valid <= 1'b1;
                rd_data  <= bus_rdata;
                rd_last  <= last_beat;
              end
              if (last_beat) begin
                reqn  <= DISABLE;
                done  <= 1'b1;
                state <= REL;
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end
          end else if (!wr_q) begin
            bus_valid <= 1'b1;
            bus_write <= 1'b0;
          end else if (wd_valid) begin
            bus_wdata <= wd_data;
            bus_valid <= 1'b1;
            bus_write <= 1'b1;
          end
        end
        REL: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: one task per scenario, inline checks.
module tb_bus_requester;

  logic        bus_clk = 1'b0;
  logic        bus_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wd_valid = 1'b0;
  logic [31:0] wd_data = '0;
  logic        wd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        err;
  logic        reqn;
  logic        grntn = 1'b1;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  bus_requester #(.TIMEOUT(8)) dut (
    .bus_clk   (bus_clk),
    .bus_rst   (bus_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_data   (wd_data),
    .wd_ready  (wd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err),
    .reqn      (reqn),
    .grntn     (grntn),
    .bus_valid (bus_valid),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 bus_clk = ~bus_clk;

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) break;
      step;
    end
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL idle_ready got=%b exp=1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    #1 bus_rst = 1'b1;
    step;
    step;
    n_total++;
    if (reqn !== 1'b1) $display("FAIL rst_reqn got=%b exp=1", reqn); else n_pass++;
    n_total++;
    if (bus_valid !== 1'b0) $display("FAIL rst_bus_valid got=%b exp=0", bus_valid); else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); else n_pass++;
    n_total++;
    if ({wd_ready, rd_valid, rd_last, done, err, bus_write} !== 6'b0)
      $display("FAIL rst_flags got=%b exp=000000", {wd_ready, rd_valid, rd_last, done, err, bus_write});
    else n_pass++;
    n_total++;
    if ({bus_addr, bus_wdata, rd_data} !== 96'h0)
      $display("FAIL rst_data got=%h/%h/%h exp=0", bus_addr, bus_wdata, rd_data);
    else n_pass++;
    n_total++;
    if (dbg_state !== 2'd0) $display("FAIL rst_state got=%0d exp=0", dbg_state); else n_pass++;
    bus_rst = 1'b0;
    #1;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL rel_cmd_ready_low got=%b exp=0", cmd_ready); else n_pass++;
    step;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL rel_cmd_ready_high got=%b exp=1", cmd_ready); else n_pass++;
  endtask

  task automatic test_read_burst;
    logic [31:0] exp_addr [4];
    int beats = 0;
    int rds = 0;
    int dones = 0;
    int errs = 0;
    exp_addr[0] = 32'h0000_1000;
    exp_addr[1] = 32'h0000_1004;
    exp_addr[2] = 32'h0000_1008;
    exp_addr[3] = 32'h0000_100C;
    grntn = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0000_1000;
    cmd_len = 4'd3;
    step;
    cmd_valid = 1'b0;
    n_total++;
    if (reqn !== 1'b0) $display("FAIL rb_reqn_low got=%b exp=0", reqn); else n_pass++;
    step;
    step;
    grntn = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step;
      if (rd_valid) begin
        n_total++;
        if (rd_data !== (32'hA5A5_0000 + 32'(rds)))
          $display("FAIL rb_rd_data got=%h exp=%h", rd_data, 32'hA5A5_0000 + 32'(rds));
        else n_pass++;
        n_total++;
        if (rd_last !== (rds == 3)) $display("FAIL rb_rd_last got=%b exp=%b", rd_last, (rds == 3));
        else n_pass++;
        rds++;
      end
      if (done) dones++;
      if (err) errs++;
      if (bus_valid) begin
        if (beats < 4) begin
          n_total++;
          if (bus_addr !== exp_addr[beats])
            $display("FAIL rb_addr got=%h exp=%h", bus_addr, exp_addr[beats]);
          else n_pass++;
        end
        bus_rdata = 32'hA5A5_0000 + 32'(beats);
        bus_ack = 1'b1;
        beats++;
      end else begin
        bus_ack = 1'b0;
      end
    end
    bus_ack = 1'b0;
    n_total++;
    if (beats != 4) $display("FAIL rb_beats got=%0d exp=4", beats); else n_pass++;
    n_total++;
    if (rds != 4) $display("FAIL rb_rd_count got=%0d exp=4", rds); else n_pass++;
    n_total++;
    if (dones != 1) $display("FAIL rb_done_count got=%0d exp=1", dones); else n_pass++;
    n_total++;
    if (errs != 0) $display("FAIL rb_err_count got=%0d exp=0", errs); else n_pass++;
    n_total++;
    if (reqn !== 1'b1) $display("FAIL rb_reqn_after got=%b exp=1", reqn); else n_pass++;
    grntn = 1'b1;
  endtask

  task automatic test_parked_write;
    int lat = -1;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h0000_0020;
    cmd_len = 4'd0;
    wd_valid = 1'b1;
    wd_data = 32'hDEAD_BEEF;
    step;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step;
      if (bus_valid) begin
        lat = c;
        break;
      end
    end
    wd_valid = 1'b0;
    n_total++;
    if (!(lat >= 1 && lat <= 3)) $display("FAIL pw_latency got=%0d exp=1..3", lat); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if ({bus_valid, bus_write, bus_addr, bus_wdata} !== {1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF})
        $display("FAIL pw_hold got=%b/%b/%h/%h exp=1/1/00000020/deadbeef",
                 bus_valid, bus_write, bus_addr, bus_wdata);
      else n_pass++;
      if (c < 3) step;
    end
    bus_ack = 1'b1;
    step;
    bus_ack = 1'b0;
    n_total++;
    if ({done, bus_valid, reqn} !== 3'b101)
      $display("FAIL pw_complete got=%b exp=101", {done, bus_valid, reqn});
    else n_pass++;
    step;
    n_total++;
    if (done !== 1'b0) $display("FAIL pw_done_once got=%b exp=0", done); else n_pass++;
    grntn = 1'b1;
  endtask

  task automatic test_wrap;
    logic [31:0] got [2];
    int beats = 0;
    int dones = 0;
    got[0] = '0;
    got[1] = 32'hFFFF_FFFF;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'hFFFF_FFFC;
    cmd_len = 4'd1;
    step;
    cmd_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step;
      if (done) dones++;
      if (bus_valid) begin
        if (beats < 2) got[beats] = bus_addr;
        beats++;
        bus_ack = 1'b1;
      end else begin
        bus_ack = 1'b0;
      end
    end
    bus_ack = 1'b0;
    n_total++;
    if (beats != 2) $display("FAIL wr_beats got=%0d exp=2", beats); else n_pass++;
    n_total++;
    if (got[0] !== 32'hFFFF_FFFC) $display("FAIL wr_addr0 got=%h exp=fffffffc", got[0]); else n_pass++;
    n_total++;
    if (got[1] !== 32'h0000_0000) $display("FAIL wr_addr1 got=%h exp=00000000", got[1]); else n_pass++;
    n_total++;
    if (dones != 1) $display("FAIL wr_done_count got=%0d exp=1", dones); else n_pass++;
    grntn = 1'b1;
  endtask

  task automatic test_timeout;
    logic found = 1'b0;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0000_0040;
    cmd_len = 4'd0;
    step;
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step;
      if (bus_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (found !== 1'b1) $display("FAIL to_valid_rise got=%b exp=1", found); else n_pass++;
    for (int k = 1; k < 8; k++) begin
      step;
      n_total++;
      if ({bus_valid, err} !== 2'b10)
        $display("FAIL to_waiting cycle=%0d got=%b exp=10", k, {bus_valid, err});
      else n_pass++;
    end
    step;
    n_total++;
    if ({err, bus_valid, reqn, done} !== 4'b1010)
      $display("FAIL to_abort got=%b exp=1010", {err, bus_valid, reqn, done});
    else n_pass++;
    n_total++;
    if ({cmd_ready, dbg_state} !== {1'b0, 2'd3})
      $display("FAIL to_rel got=%b/%0d exp=0/3", cmd_ready, dbg_state);
    else n_pass++;
    step;
    n_total++;
    if ({err, cmd_ready} !== 2'b01) $display("FAIL to_back_idle got=%b exp=01", {err, cmd_ready});
    else n_pass++;
    grntn = 1'b1;
  endtask

  task automatic test_grant_loss;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0000_0080;
    cmd_len = 4'd1;
    step;
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step;
      if (bus_valid) break;
    end
    grntn = 1'b1;
    step;
    n_total++;
    if ({err, bus_valid, reqn, done} !== 4'b1010)
      $display("FAIL gl_abort got=%b exp=1010", {err, bus_valid, reqn, done});
    else n_pass++;
  endtask

  task automatic test_write_stall;
    int bad = 0;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h0000_0060;
    cmd_len = 4'd0;
    wd_valid = 1'b0;
    step;
    cmd_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step;
      if ({wd_ready, bus_valid, err} !== 3'b100) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL ws_wait bad_cycles got=%0d exp=0", bad); else n_pass++;
    wd_valid = 1'b1;
    wd_data = 32'h1234_5678;
    step;
    wd_valid = 1'b0;
    n_total++;
    if ({bus_valid, bus_wdata} !== {1'b1, 32'h1234_5678})
      $display("FAIL ws_issue got=%b/%h exp=1/12345678", bus_valid, bus_wdata);
    else n_pass++;
    bus_ack = 1'b1;
    step;
    bus_ack = 1'b0;
    n_total++;
    if ({done, err} !== 2'b10) $display("FAIL ws_done got=%b exp=10", {done, err}); else n_pass++;
    grntn = 1'b1;
  endtask

  task automatic test_reset_mid;
    int nb = 0;
    int pulses = 0;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0000_0100;
    cmd_len = 4'd3;
    step;
    cmd_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step;
      if (bus_valid) begin
        nb++;
        if (nb == 2) break;
        bus_ack = 1'b1;
      end else begin
        bus_ack = 1'b0;
      end
    end
    bus_ack = 1'b0;
    n_total++;
    if (nb != 2) $display("FAIL rm_beat2 got=%0d exp=2", nb); else n_pass++;
    bus_rst = 1'b1;
    #1;
    n_total++;
    if ({reqn, bus_valid} !== 2'b10) $display("FAIL rm_async got=%b exp=10", {reqn, bus_valid});
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) bus_rst = 1'b0;
      step;
      if (done || err) pulses++;
    end
    n_total++;
    if (pulses != 0) $display("FAIL rm_no_pulse got=%0d exp=0", pulses); else n_pass++;
    grntn = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] got [2];
    int hs = 0;
    int low_runs = 0;
    int dones = 0;
    int nbeats = 0;
    logic prev_reqn = 1'b1;
    got[0] = '0;
    got[1] = '0;
    grntn = 1'b0;
    wait_idle;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0000_0300;
    cmd_len = 4'd0;
    for (int c = 0; c < 40; c++) begin
      if (cmd_valid && cmd_ready) hs++;
      step;
      if (hs == 1) cmd_addr = 32'h0000_0304;
      if (hs == 2) cmd_valid = 1'b0;
      if (reqn == 1'b0 && prev_reqn == 1'b1) low_runs++;
      prev_reqn = reqn;
      if (done) dones++;
      if (bus_valid) begin
        if (nbeats < 2) got[nbeats] = bus_addr;
        nbeats++;
        bus_ack = 1'b1;
      end else begin
        bus_ack = 1'b0;
      end
    end
    bus_ack = 1'b0;
    cmd_valid = 1'b0;
    n_total++;
    if (hs != 2) $display("FAIL bb_handshakes got=%0d exp=2", hs); else n_pass++;
    n_total++;
    if (dones != 2) $display("FAIL bb_dones got=%0d exp=2", dones); else n_pass++;
    n_total++;
    if (low_runs != 2) $display("FAIL bb_reqn_gap low_runs got=%0d exp=2", low_runs); else n_pass++;
    n_total++;
    if ({got[0], got[1]} !== {32'h0000_0300, 32'h0000_0304})
      $display("FAIL bb_addrs got=%h/%h exp=00000300/00000304", got[0], got[1]);
    else n_pass++;
    grntn = 1'b1;
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset;
    test_read_burst;
    test_parked_write;
    test_wrap;
    test_timeout;
    test_grant_loss;
    test_write_stall;
    test_reset_mid;
    test_back_to_back;
    wait_idle;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
